// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings, FSM states and
// small op-decode helpers.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } mdu_state_e;

  function automatic logic op_is_div(logic [1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: abs() on operand entry, sign restore on result exit.
module mdu_sign_fix #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] x,
  input  logic         neg,
  output logic [N-1:0] y
);

  assign y = neg ? -x : x;

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide on
// magnitudes, with sign correction at the end, flush-cancel and divide-by-zero reporting.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter bit          MUL_FAST = 1'b0,
  parameter int unsigned CNT_W    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int unsigned W2 = 2 * WIDTH;

  mdu_state_e       state_q, state_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d, araw_q, araw_d, hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic             done_q, done_d, dz_q, dz_d;

  logic             idle, accept, in_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs, quo, rem;
  logic [W2-1:0]    prod, fast_prod, mul_step, div_step;
  logic [WIDTH:0]   mul_sum, rem_sh, diff;

  assign idle   = (state_q == IDLE);
  assign accept = idle & start & ~flush;
  assign in_div = op_is_div(op);
  assign a_neg  = op_is_signed(op) & a[WIDTH-1];
  assign b_neg  = op_is_signed(op) & b[WIDTH-1];

  mdu_sign_fix #(.N(WIDTH)) u_abs_a (.x(a), .neg(a_neg), .y(a_abs));
  mdu_sign_fix #(.N(WIDTH)) u_abs_b (.x(b), .neg(b_neg), .y(b_abs));
  mdu_sign_fix #(.N(W2)) u_fix_prod (.x(acc_q), .neg(neg_lo_q), .y(prod));
  mdu_sign_fix #(.N(WIDTH)) u_fix_quo (.x(acc_q[WIDTH-1:0]), .neg(neg_lo_q), .y(quo));
  mdu_sign_fix #(.N(WIDTH)) u_fix_rem (.x(acc_q[W2-1:WIDTH]), .neg(neg_hi_q), .y(rem));

  if (MUL_FAST) begin : g_fast
    assign fast_prod = W2'(a_abs) * W2'(b_abs);
  end else begin : g_iter
    assign fast_prod = '0;
  end

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; WIDTH+1-bit trial keeps the carry-out.
  assign rem_sh   = acc_q[W2-1:WIDTH-1];
  assign diff     = rem_sh - {1'b0, opnd_q};
  assign div_step = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    araw_d   = araw_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          div_d    = in_div;
          araw_d   = a;
          opnd_d   = in_div ? b_abs : a_abs;
          acc_d    = {{WIDTH{1'b0}}, (in_div ? a_abs : b_abs)};
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          cnt_d    = '0;
          dz_d     = 1'b0;
          if (MUL_FAST && !in_div) begin
            acc_d   = fast_prod;
            state_d = FIN;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = div_q ? div_step : mul_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (div_q && (opnd_q == '0)) begin
          hi_d = araw_q;
          lo_d = '1;
          dz_d = 1'b1;
        end else if (div_q) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          hi_d = prod[W2-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush abandons the operation without touching the architectural results.
    if (flush && !idle) begin
      state_d = IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dz_d    = dz_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      opnd_q   <= '0;
      araw_q   <= '0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      araw_q   <= araw_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  assign busy  = !idle && !done_q;
  assign stall = (start & idle & ~flush) | busy;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign dz    = dz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: an iterative instance and a fast-multiply instance share
// operands; expected results and done cycles are queued at issue and checked on done.
module tb_mdu_iter;
  import mdu_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_s = 1'b0, start_f = 1'b0, flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy_s, stall_s, done_s, dz_s, busy_f, stall_f, done_f, dz_f;
  logic [31:0] hi_s, lo_s, hi_f, lo_f;

  int   cyc = 0, compared = 0, failed = 0, id_n = 0, done_cnt_s = 0, done_cnt_f = 0;
  exp_t q_s[$];
  exp_t q_f[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mdu_iter #(.WIDTH(32), .MUL_FAST(1'b0)) u_dut_s (
    .clk(clk), .rst(rst), .start(start_s), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy_s), .stall(stall_s), .done(done_s), .hi(hi_s), .lo(lo_s), .dz(dz_s)
  );

  mdu_iter #(.WIDTH(32), .MUL_FAST(1'b1)) u_dut_f (
    .clk(clk), .rst(rst), .start(start_f), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy_f), .stall(stall_f), .done(done_f), .hi(hi_f), .lo(lo_f), .dz(dz_f)
  );

  task automatic chk(input string nm, input int id, input logic [63:0] act,
                     input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s (vector %0d): got %0h, expected %0h", nm, id, act, exp);
    end
  endtask

  // Monitors: pop and compare whenever a DUT strobes done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done_s) begin
      done_cnt_s++;
      if (q_s.size() == 0) begin
        compared++;
        failed++;
        $display("FAIL slow_unexpected_done: got done=1, expected none (hi %0h lo %0h)",
                 hi_s, lo_s);
      end else begin
        e = q_s.pop_front();
        chk("slow_hi", e.id, hi_s, e.hi);
        chk("slow_lo", e.id, lo_s, e.lo);
        chk("slow_dz", e.id, dz_s, e.dz);
        chk("slow_done_cycle", e.id, cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done_f) begin
      done_cnt_f++;
      if (q_f.size() == 0) begin
        compared++;
        failed++;
        $display("FAIL fast_unexpected_done: got done=1, expected none (hi %0h lo %0h)",
                 hi_f, lo_f);
      end else begin
        e = q_f.pop_front();
        chk("fast_hi", e.id, hi_f, e.hi);
        chk("fast_lo", e.id, lo_f, e.lo);
        chk("fast_dz", e.id, dz_f, e.dz);
        chk("fast_done_cycle", e.id, cyc, e.cyc);
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 of the done cycle.
  task automatic issue(input bit fast, input logic [1:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edz);
    exp_t e;
    int   lat, n, sc;
    lat = (fast && !o[1]) ? 1 : 33;
    op = o;
    a = av;
    b = bv;
    if (fast) start_f = 1'b1;
    else start_s = 1'b1;
    e.hi = ehi;
    e.lo = elo;
    e.dz = edz;
    e.cyc = cyc + 1 + lat;
    e.id = id_n;
    id_n++;
    if (fast) q_f.push_back(e);
    else q_s.push_back(e);
    #1;
    chk("stall_start_cycle", e.id, fast ? stall_f : stall_s, 1);
    @(posedge clk);
    #1;
    start_s = 1'b0;
    start_f = 1'b0;
    n = 0;
    sc = 0;
    while (!(fast ? done_f : done_s) && n < 60) begin
      if (fast ? stall_f : stall_s) sc++;
      n++;
      @(posedge clk);
      #1;
    end
    if (n >= 60) begin
      compared++;
      failed++;
      $display("FAIL done_timeout (vector %0d): got no done in 60 cycles, expected %0d",
               e.id, lat);
    end else begin
      chk("stall_cycles", e.id, sc, lat);
      chk("stall_in_done_cycle", e.id, fast ? stall_f : stall_s, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dref;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", -1, {busy_s, busy_f}, 2'b00);
    chk("rst_done", -1, {done_s, done_f}, 2'b00);
    chk("rst_dz", -1, {dz_s, dz_f}, 2'b00);
    chk("rst_stall", -1, {stall_s, stall_f}, 2'b00);
    chk("rst_hilo_s", -1, {hi_s, lo_s}, 64'h0);
    chk("rst_hilo_f", -1, {hi_f, lo_f}, 64'h0);

    issue(0, MDU_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    issue(0, MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    issue(1, MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    issue(1, MDU_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    issue(1, MDU_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 0);
    issue(0, MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
    issue(0, MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    issue(0, MDU_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 0);
    issue(0, MDU_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
    issue(0, MDU_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 0);
    issue(0, MDU_DIVU,  32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    issue(0, MDU_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1);
    issue(0, MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
    issue(0, MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1);
    issue(0, MDU_DIVU,  32'h5678_1234, 32'h0001_0000, 32'h0000_1234, 32'h0000_5678, 0);

    // Abandoned DIV: a second start while busy, then flush about 10 cycles in.
    op = MDU_DIV;
    a = 32'd100;
    b = 32'd3;
    start_s = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    dref = done_cnt_s;
    repeat (3) @(posedge clk);
    #1;
    op = MDU_MULTU;
    a = 32'd9;
    b = 32'd9;
    start_s = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    chk("busy_during_div", -1, busy_s, 1);
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", -1, busy_s, 0);
    chk("flush_hilo", -1, {hi_s, lo_s}, {32'h1234, 32'h5678});
    chk("flush_dz", -1, dz_s, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_no_done", -1, done_cnt_s - dref, 0);
    chk("flush_hilo_held", -1, {hi_s, lo_s}, {32'h1234, 32'h5678});

    // start and flush together: nothing accepted.
    op = MDU_MULTU;
    a = 32'd2;
    b = 32'd3;
    start_s = 1'b1;
    flush = 1'b1;
    #1;
    chk("start_flush_stall", -1, stall_s, 0);
    @(posedge clk);
    #1;
    start_s = 1'b0;
    flush = 1'b0;
    chk("start_flush_busy", -1, busy_s, 0);
    dref = done_cnt_s;
    repeat (40) @(posedge clk);
    #1;
    chk("start_flush_no_done", -1, done_cnt_s - dref, 0);

    // Reset mid-CALC, then a fresh operation right after.
    issue(0, MDU_DIVU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1);
    op = MDU_DIV;
    a = 32'd100;
    b = 32'd7;
    start_s = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("busy_before_rst", -1, busy_s, 1);
    q_s.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", -1, busy_s, 0);
    chk("midrst_hilo", -1, {hi_s, lo_s}, 64'h0);
    chk("midrst_dz_done", -1, {dz_s, done_s}, 2'b00);
    issue(0, MDU_MULTU, 32'd6, 32'd7, 32'h0, 32'h0000_002A, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("slow_queue_drained", -1, q_s.size(), 0);
    chk("fast_queue_drained", -1, q_f.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
